// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit: owns the fetch PC, drives imem req/ack, buffers {pc, instr} to decode.
// Optional macro FETCH_STATS_EN adds stat_fetched / stat_flushed counters.
module fetch_queue_unit #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int unsigned     DEPTH    = 4,
    parameter int unsigned     STEP     = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_instr
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0]     stat_fetched,
    output logic [31:0]     stat_flushed
`endif
);

    localparam int unsigned     PW      = $clog2(DEPTH);
    localparam int unsigned     CW      = PW + 1;
    localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);
    localparam logic [XLEN-1:0] STEP_C  = XLEN'(STEP);

    typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] req_addr_q, req_addr_d;
    logic [CW-1:0]   count_q;
    logic [PW-1:0]   rd_ptr_q, wr_ptr_q;
    logic [XLEN-1:0] pc_mem_q [DEPTH];
    logic [XLEN-1:0] instr_mem_q [DEPTH];
    logic            push, pop, flush;
    logic [CW-1:0]   count_after;

    assign imem_req    = (state_q != IDLE);
    assign imem_addr   = req_addr_q;
    assign out_valid   = (count_q != '0);
    assign out_pc      = out_valid ? pc_mem_q[rd_ptr_q] : '0;
    assign out_instr   = out_valid ? instr_mem_q[rd_ptr_q] : '0;
    assign pop         = out_valid && out_ready;
    assign flush       = redirect_valid;
    // A request only issues with a free slot, so this cannot exceed DEPTH.
    assign count_after = count_q + CW'(1) - CW'(pop);

    // Next-state logic: redirect overrides the fetch PC in every state.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_addr_d = req_addr_q;
        push       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!redirect_valid && count_q < DEPTH_C) begin
                    state_d    = REQ;
                    req_addr_d = fetch_pc_q;
                end
            end
            REQ: begin
                if (redirect_valid) begin
                    state_d = imem_ack ? IDLE : DRAIN;
                end else if (imem_ack) begin
                    push       = 1'b1;
                    fetch_pc_d = fetch_pc_q + STEP_C;
                    if (count_after < DEPTH_C) begin
                        req_addr_d = fetch_pc_q + STEP_C;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DRAIN: begin
                if (imem_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc & ~XLEN'(3);
        end
    end

    // Control registers: FSM state, fetch PC and outstanding request address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            req_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_addr_q <= req_addr_d;
        end
    end

    // FIFO bookkeeping; a flush wins over any same-cycle pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else if (flush) begin
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    // FIFO storage; empty head is masked to zero at the outputs.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem_q[wr_ptr_q]    <= req_addr_q;
            instr_mem_q[wr_ptr_q] <= imem_rdata;
        end
    end

`ifdef FETCH_STATS_EN
    logic [31:0] fetched_q, flushed_q;
    logic [31:0] flush_amt;
    logic        drained;

    // Entries popped in the redirect cycle reached decode, so are not flushed.
    assign flush_amt    = flush ? (32'(count_q) - 32'(pop)) : 32'd0;
    assign drained      = (state_q == DRAIN) && imem_ack;
    assign stat_fetched = fetched_q;
    assign stat_flushed = flushed_q;

    // Statistics counters, free-running and wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetched_q <= '0;
            flushed_q <= '0;
        end else begin
            fetched_q <= fetched_q + 32'(push);
            flushed_q <= flushed_q + flush_amt + 32'(drained);
        end
    end
`endif

endmodule

// File: tb/tb_fetch_queue_unit.sv
// tb_fetch_queue_unit: vector table, directed redirect sequences and a
// randomized run checked against a PC-stream reference model.
module tb_fetch_queue_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
`ifdef FETCH_STATS_EN
    logic [31:0] stat_fetched;
    logic [31:0] stat_flushed;
`endif

    fetch_queue_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr)
`ifdef FETCH_STATS_EN
        ,
        .stat_fetched   (stat_fetched),
        .stat_flushed   (stat_flushed)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic        rdy;
        logic        ack;
        logic        req;
        logic [31:0] addr;
        logic        vld;
        logic [31:0] pc;
    } vec_t;

    vec_t tbl [17];

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h0000_0013;
    endfunction

    function automatic vec_t mk(input int rdy, input int ack, input int req,
                                input int addr, input int vld, input int pc);
        vec_t v;
        v.rdy  = (rdy != 0);
        v.ack  = (ack != 0);
        v.req  = (req != 0);
        v.addr = addr;
        v.vld  = (vld != 0);
        v.pc   = pc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string name, input logic req, input logic [31:0] addr,
                           input logic vld, input logic [31:0] pc);
        chk({name, ".req"},   32'(imem_req),  32'(req));
        chk({name, ".addr"},  imem_addr,      addr);
        chk({name, ".valid"}, 32'(out_valid), 32'(vld));
        chk({name, ".pc"},    out_pc,         pc);
        chk({name, ".instr"}, out_instr,      vld ? instr_of(pc) : 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_ack       = 1'b0;
        imem_rdata     = '0;
        out_ready      = 1'b0;
        repeat (2) @(negedge clk);
        chk_out("reset", 1'b0, 32'd0, 1'b0, 32'd0);
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] exp_pc;
        logic [31:0] prev_addr;
        logic [31:0] r;
        logic        prev_redir, prev_req, prev_ack;
        int          pops;

        // rdy ack | req addr vld pc  (outputs checked before inputs applied)
        tbl[0]  = mk(1, 0, 0,  0, 0,  0);
        tbl[1]  = mk(1, 1, 1,  0, 0,  0);
        tbl[2]  = mk(1, 1, 1,  4, 1,  0);
        tbl[3]  = mk(1, 1, 1,  8, 1,  4);
        tbl[4]  = mk(1, 1, 1, 12, 1,  8);
        tbl[5]  = mk(0, 1, 1, 16, 1, 12);
        tbl[6]  = mk(0, 1, 1, 20, 1, 12);
        tbl[7]  = mk(0, 1, 1, 24, 1, 12);
        tbl[8]  = mk(0, 0, 0, 24, 1, 12);
        tbl[9]  = mk(1, 0, 0, 24, 1, 12);
        tbl[10] = mk(0, 0, 0, 24, 1, 16);
        tbl[11] = mk(0, 0, 1, 28, 1, 16);
        tbl[12] = mk(0, 0, 1, 28, 1, 16);
        tbl[13] = mk(0, 1, 1, 28, 1, 16);
        tbl[14] = mk(1, 0, 0, 28, 1, 16);
        tbl[15] = mk(1, 0, 0, 28, 1, 20);
        tbl[16] = mk(1, 0, 1, 32, 1, 24);

        #1;
        do_reset();
        for (int i = 0; i < 17; i++) begin
            chk_out($sformatf("vec%0d", i), tbl[i].req, tbl[i].addr, tbl[i].vld, tbl[i].pc);
            out_ready  = tbl[i].rdy;
            imem_ack   = tbl[i].ack;
            imem_rdata = instr_of(imem_addr);
            @(negedge clk);
        end

        // Redirect while a request is pending: drain the stale response.
        do_reset();
        @(negedge clk);
        chk_out("t4_issue", 1'b1, 32'd0, 1'b0, 32'd0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        @(negedge clk);
        chk_out("t4_drain", 1'b1, 32'd0, 1'b0, 32'd0);
        redirect_valid = 1'b0;
        imem_ack       = 1'b1;
        imem_rdata     = 32'hDEAD_BEEF;
        @(negedge clk);
        chk_out("t4_idle", 1'b0, 32'd0, 1'b0, 32'd0);
        imem_ack = 1'b0;
        @(negedge clk);
        chk_out("t4_reissue", 1'b1, 32'h100, 1'b0, 32'd0);
        imem_ack   = 1'b1;
        imem_rdata = instr_of(32'h100);
        @(negedge clk);
        imem_ack = 1'b0;
        chk_out("t4_entry", 1'b1, 32'h104, 1'b1, 32'h100);
        rst_n = 1'b0;
        #1;
        chk("rst_drops_req", 32'(imem_req), 32'd0);

        // Redirect coinciding with an ack while two entries are queued.
        do_reset();
        imem_ack = 1'b1;
        repeat (3) begin
            imem_rdata = instr_of(imem_addr);
            @(negedge clk);
        end
        chk_out("t5_two", 1'b1, 32'd8, 1'b1, 32'd0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h103;
        imem_rdata     = instr_of(imem_addr);
        @(negedge clk);
        chk_out("t5_flush", 1'b0, 32'd8, 1'b0, 32'd0);
        redirect_valid = 1'b0;
        imem_ack       = 1'b0;
        out_ready      = 1'b1;
        @(negedge clk);
        chk_out("t5_reissue", 1'b1, 32'h100, 1'b0, 32'd0);
        imem_ack   = 1'b1;
        imem_rdata = instr_of(32'h100);
        @(negedge clk);
        imem_ack = 1'b0;
        chk_out("t5_head", 1'b1, 32'h104, 1'b1, 32'h100);

`ifdef FETCH_STATS_EN
        // Five pushes, two popped, then a redirect flushes the three left.
        do_reset();
        imem_ack = 1'b1;
        for (int k = 0; k < 6; k++) begin
            out_ready  = (k == 3 || k == 4);
            imem_rdata = instr_of(imem_addr);
            @(negedge clk);
        end
        chk("t6_fetched_pre", stat_fetched, 32'd5);
        chk("t6_flushed_pre", stat_flushed, 32'd0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        imem_ack       = 1'b0;
        out_ready      = 1'b0;
        @(negedge clk);
        redirect_valid = 1'b0;
        chk("t6_fetched", stat_fetched, 32'd5);
        chk("t6_flushed", stat_flushed, 32'd3);
        chk("t6_valid", 32'(out_valid), 32'd0);
`endif

        // Random traffic: decode must see a sequential PC stream that
        // restarts at each (word-aligned) redirect target.
        do_reset();
        exp_pc     = 32'd0;
        pops       = 0;
        prev_redir = 1'b0;
        prev_req   = 1'b0;
        prev_ack   = 1'b0;
        prev_addr  = '0;
        for (int c = 0; c < 3000; c++) begin
            if (prev_redir) chk("rnd_flush_empty", 32'(out_valid), 32'd0);
            if (prev_req && !prev_ack) begin
                chk("rnd_req_held", 32'(imem_req), 32'd1);
                chk("rnd_addr_stable", imem_addr, prev_addr);
            end
            if (!out_valid) chk("rnd_empty_pc", out_pc, 32'd0);

            out_ready      = ($urandom_range(3) != 0);
            redirect_valid = ($urandom_range(15) == 0);
            r = $urandom;
            if ($urandom_range(3) == 0) r[31:4] = 28'hFFF_FFFF;
            redirect_pc = r;
            imem_ack    = imem_req && ($urandom_range(2) != 0);
            imem_rdata  = instr_of(imem_addr);

            if (out_valid && out_ready) begin
                chk("rnd_pop_pc", out_pc, exp_pc);
                chk("rnd_pop_instr", out_instr, instr_of(exp_pc));
                exp_pc = exp_pc + 32'd4;
                pops++;
            end
            if (redirect_valid) exp_pc = redirect_pc & ~32'd3;

            prev_redir = redirect_valid;
            prev_req   = imem_req;
            prev_ack   = imem_ack;
            prev_addr  = imem_addr;
            @(negedge clk);
        end
        chk("rnd_progress", 32'(pops > 300), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
